// File: rtl/stepper_move_if.sv
// Command channel between the floor-request logic (master) and the stepper
// move sequencer (slave): an absolute target position plus a step interval,
// transferred on a valid/ready handshake.
interface stepper_move_if #(
  parameter int POS_W = 16,
  parameter int DIV_W = 20
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [POS_W-1:0] cmd_target;
  logic [DIV_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/stepper_move_ctrl.sv
// Move sequencer for the elevator stepper drive.
// Accepts absolute-position moves, emits single-cycle step strobes spaced by a
// programmable interval together with a direction level, tracks the shaft
// position, and pulses done after a settle dwell equal to one interval.
//
// Optional build macro: STEP_RAMP_EN
//   defined   -> acceleration ramp; interval before step k is
//                P + (RAMP_EXTRA >> (k-1)).
//   undefined -> every interval is exactly P; no ramp logic is built.
module stepper_move_ctrl #(
  parameter int POS_W      = 16,
  parameter int DIV_W      = 20,
  parameter int RAMP_EXTRA = 256
) (
  input  logic             clk,
  input  logic             reset,
  stepper_move_if.slave    cmd_if,
  input  logic             i_abort,
  output logic             o_step,
  output logic             o_dir,
  output logic [POS_W-1:0] o_position,
  output logic             o_busy,
  output logic             o_done
);

  // One spare bit so that P plus the ramp term never overflows the counter.
  localparam int CNT_W = DIV_W + 1;

  // The ramp term is held in a DIV_W-bit register, so it has to fit there.
  if (RAMP_EXTRA < 0 || RAMP_EXTRA >= (1 << DIV_W)) begin : g_ramp_extra_range
    $error("RAMP_EXTRA must lie in 0 .. 2**DIV_W-1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DWELL,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [POS_W-1:0]   r_target;
  logic [DIV_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_step;
  logic               r_dir;
  logic [POS_W-1:0]   r_position;
  logic               r_done;

  logic [POS_W-1:0]   w_target_nxt;
  logic [DIV_W-1:0]   w_period_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_step_nxt;
  logic               w_dir_nxt;
  logic [POS_W-1:0]   w_position_nxt;
  logic               w_done_nxt;

  logic               w_accept;
  logic [DIV_W-1:0]   w_period_eff;
  logic [CNT_W-1:0]   w_period_ext;
  logic [CNT_W-1:0]   w_first_load;
  logic [CNT_W-1:0]   w_step_load;
  logic               w_cnt_expired;

  // Handshake is only open in IDLE; a zero interval behaves like one cycle.
  assign w_accept      = cmd_if.cmd_valid && (r_state == S_IDLE);
  assign w_period_eff  = (cmd_if.cmd_period == '0) ? DIV_W'(1) : cmd_if.cmd_period;
  assign w_period_ext  = {1'b0, r_period};
  assign w_cnt_expired = (r_cnt <= CNT_W'(1));

`ifdef STEP_RAMP_EN
  localparam logic [DIV_W-1:0] LP_RAMP = DIV_W'(RAMP_EXTRA);

  logic [DIV_W-1:0] r_extra;
  logic [DIV_W-1:0] w_extra_nxt;

  // First interval carries the full ramp term; each later one carries half
  // of the term used before it.
  assign w_first_load = {1'b0, w_period_eff} + {1'b0, LP_RAMP};
  assign w_step_load  = w_period_ext + {1'b0, (r_extra >> 1)};

  // Ramp term register: reloaded on acceptance, halved at every step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_extra <= '0;
    end else begin
      r_extra <= w_extra_nxt;
    end
  end

  // Next value of the ramp term.
  always_comb begin
    w_extra_nxt = r_extra;
    if (w_accept) begin
      w_extra_nxt = LP_RAMP;
    end else if (r_state == S_RUN && !i_abort && w_cnt_expired) begin
      w_extra_nxt = r_extra >> 1;
    end
  end
`else
  assign w_first_load = {1'b0, w_period_eff};
  assign w_step_load  = w_period_ext;
`endif

  // State and datapath registers; everything observable resets to idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_target   <= '0;
      r_period   <= '0;
      r_cnt      <= '0;
      r_step     <= 1'b0;
      r_dir      <= 1'b1;
      r_position <= '0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values; the combinational block below uses
      // blocking assignments because later lines read earlier results.
      r_state    <= w_next_state;
      r_target   <= w_target_nxt;
      r_period   <= w_period_nxt;
      r_cnt      <= w_cnt_nxt;
      r_step     <= w_step_nxt;
      r_dir      <= w_dir_nxt;
      r_position <= w_position_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and next-register decode for the move sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next_state   = r_state;
    w_target_nxt   = r_target;
    w_period_nxt   = r_period;
    w_cnt_nxt      = r_cnt;
    w_step_nxt     = 1'b0;
    w_dir_nxt      = r_dir;
    w_position_nxt = r_position;
    w_done_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_target_nxt = cmd_if.cmd_target;
          w_period_nxt = w_period_eff;
          if (cmd_if.cmd_target == r_position) begin
            // Already there: no steps, direction left as it was.
            w_next_state = S_DONE;
          end else begin
            w_dir_nxt    = (cmd_if.cmd_target > r_position);
            w_cnt_nxt    = w_first_load;
            w_next_state = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (i_abort) begin
          // Abort beats a coincident step boundary; settle before reporting.
          w_cnt_nxt    = w_period_ext;
          w_next_state = S_DWELL;
        end else if (w_cnt_expired) begin
          w_step_nxt     = 1'b1;
          w_position_nxt = r_dir ? (r_position + POS_W'(1))
                                 : (r_position - POS_W'(1));
          if (w_position_nxt == r_target) begin
            w_cnt_nxt    = w_period_ext;
            w_next_state = S_DWELL;
          end else begin
            w_cnt_nxt = w_step_load;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_DWELL: begin
        if (w_cnt_expired) begin
          w_next_state = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_DONE: begin
        // Two cycles here: the first raises done, the second returns to IDLE,
        // so busy still covers the cycle in which done is high.
        if (r_done) begin
          w_next_state = S_IDLE;
        end else begin
          w_done_nxt = 1'b1;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign cmd_if.cmd_ready = (r_state == S_IDLE);
  assign o_busy           = (r_state != S_IDLE);
  assign o_step           = r_step;
  assign o_dir            = r_dir;
  assign o_position       = r_position;
  assign o_done           = r_done;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed testbench for stepper_move_ctrl. Builds with or without
// STEP_RAMP_EN; the ramp scenario only runs when the macro is defined.
module tb_stepper_move_ctrl;

  localparam int POS_W = 16;
  localparam int DIV_W = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             abort;
  logic             step;
  logic             dir;
  logic [POS_W-1:0] position;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  stepper_move_if #(.POS_W(POS_W), .DIV_W(DIV_W)) cmd_if ();

  stepper_move_ctrl #(
    .POS_W     (POS_W),
    .DIV_W     (DIV_W),
    .RAMP_EXTRA(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_if    (cmd_if),
    .i_abort   (abort),
    .o_step    (step),
    .o_dir     (dir),
    .o_position(position),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command; the edge consumed here is edge 0 of the move.
  task automatic send_cmd(input logic [POS_W-1:0] tgt, input logic [DIV_W-1:0] per);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = tgt;
    cmd_if.cmd_period = per;
    tick();
    cmd_if.cmd_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset             = 1'b1;
    abort             = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_period = '0;
    #12;
    total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", step); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b want=1", dir); end
    total++; if (position !== 16'd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", position); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_if.cmd_ready); end
    tick();
    reset = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_idle busy=%b ready=%b want busy=0 ready=1", busy, cmd_if.cmd_ready);
    end
  endtask

  // target=5, P=4 from 0: steps after edges 4,8,12,16,20; done after edge 25.
  task automatic test_basic_move();
    logic             exp_step;
    logic [POS_W-1:0] exp_pos;
    send_cmd(16'd5, 20'd4);
    total++; if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
      bad++; $display("FAIL basic_accept busy=%b ready=%b want busy=1 ready=0", busy, cmd_if.cmd_ready);
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_step = (k % 4 == 0) && (k <= 20);
      exp_pos  = (k >= 20) ? 16'd5 : POS_W'(k / 4);
      total++; if (step !== exp_step) begin bad++; $display("FAIL basic_step k=%0d got=%b want=%b", k, step, exp_step); end
      total++; if (position !== exp_pos) begin bad++; $display("FAIL basic_pos k=%0d got=%0d want=%0d", k, position, exp_pos); end
      total++; if (done !== (k == 25)) begin bad++; $display("FAIL basic_done k=%0d got=%b want=%b", k, done, (k == 25)); end
      total++; if (busy !== (k <= 25)) begin bad++; $display("FAIL basic_busy k=%0d got=%b want=%b", k, busy, (k <= 25)); end
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL basic_dir k=%0d got=%b want=1", k, dir); end
    end
    total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b want=1", cmd_if.cmd_ready); end
  endtask

  // From 5 to 2 at P=1: steps after edges 1,2,3; dwell 1; done after edge 5.
  task automatic test_reverse_min_period();
    logic [POS_W-1:0] exp_pos;
    send_cmd(16'd2, 20'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_pos = (k >= 3) ? 16'd2 : POS_W'(5 - k);
      total++; if (step !== (k <= 3)) begin bad++; $display("FAIL rev_step k=%0d got=%b want=%b", k, step, (k <= 3)); end
      total++; if (position !== exp_pos) begin bad++; $display("FAIL rev_pos k=%0d got=%0d want=%0d", k, position, exp_pos); end
      total++; if (done !== (k == 5)) begin bad++; $display("FAIL rev_done k=%0d got=%b want=%b", k, done, (k == 5)); end
      total++; if (dir !== 1'b0) begin bad++; $display("FAIL rev_dir k=%0d got=%b want=0", k, dir); end
    end
  endtask

  // Target equal to position: no steps, dir held at 0, done after edge 1.
  task automatic test_zero_length();
    send_cmd(16'd2, 20'd3);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL zero_accept busy=%b done=%b want busy=1 done=0", busy, done);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (step !== 1'b0) begin bad++; $display("FAIL zero_step k=%0d got=%b want=0", k, step); end
      total++; if (done !== (k == 1)) begin bad++; $display("FAIL zero_done k=%0d got=%b want=%b", k, done, (k == 1)); end
      total++; if (busy !== (k <= 1)) begin bad++; $display("FAIL zero_busy k=%0d got=%b want=%b", k, busy, (k <= 1)); end
      total++; if (dir !== 1'b0) begin bad++; $display("FAIL zero_dir k=%0d got=%b want=0", k, dir); end
      total++; if (position !== 16'd2) begin bad++; $display("FAIL zero_pos k=%0d got=%0d want=2", k, position); end
    end
  endtask

  // target=100, P=10 from 0; abort sampled at edge 30 (3rd boundary).
  // Steps after edges 10,20 only; dwell 10 -> DONE at 40; done after edge 41.
  task automatic test_abort();
    logic [POS_W-1:0] exp_pos;
    do_reset();
    send_cmd(16'd100, 20'd10);
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp_pos = (k >= 20) ? 16'd2 : ((k >= 10) ? 16'd1 : 16'd0);
      total++; if (step !== (k == 10 || k == 20)) begin bad++; $display("FAIL abort_step k=%0d got=%b want=%b", k, step, (k == 10 || k == 20)); end
      total++; if (position !== exp_pos) begin bad++; $display("FAIL abort_pos k=%0d got=%0d want=%0d", k, position, exp_pos); end
      total++; if (done !== (k == 41)) begin bad++; $display("FAIL abort_done k=%0d got=%b want=%b", k, done, (k == 41)); end
      total++; if (busy !== (k <= 41)) begin bad++; $display("FAIL abort_busy k=%0d got=%b want=%b", k, busy, (k <= 41)); end
      if (k == 29) abort = 1'b1;
      if (k == 30) abort = 1'b0;
    end
  endtask

  // From 2, target=10 P=2; a second command held during RUN must not take
  // effect. Then an asynchronous reset mid-move.
  task automatic test_ignore_and_reset();
    logic [POS_W-1:0] exp_pos;
    send_cmd(16'd10, 20'd2);
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_pos = POS_W'(2 + k / 2);
      total++; if (step !== (k % 2 == 0)) begin bad++; $display("FAIL ign_step k=%0d got=%b want=%b", k, step, (k % 2 == 0)); end
      total++; if (position !== exp_pos) begin bad++; $display("FAIL ign_pos k=%0d got=%0d want=%0d", k, position, exp_pos); end
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL ign_dir k=%0d got=%b want=1", k, dir); end
      total++; if (cmd_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL ign_ready k=%0d got=%b want=0", k, cmd_if.cmd_ready); end
      if (k == 2) begin
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_target = 16'd0;
        cmd_if.cmd_period = 20'd1;
      end
    end
    #2;
    reset = 1'b1;
    #1;
    cmd_if.cmd_valid = 1'b0;
    total++; if (position !== 16'd0) begin bad++; $display("FAIL mid_reset_pos got=%0d want=0", position); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
    total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%b want=1", cmd_if.cmd_ready); end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++; if (done !== 1'b0 || step !== 1'b0 || busy !== 1'b0 || position !== 16'd0) begin
        bad++; $display("FAIL post_reset_quiet k=%0d done=%b step=%b busy=%b pos=%0d want 0 0 0 0", k, done, step, busy, position);
      end
    end
  endtask

  // P=0 behaves as P=1: 0 -> 2 steps after edges 1,2; done after edge 4.
  task automatic test_period_zero();
    send_cmd(16'd2, 20'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++; if (step !== (k <= 2)) begin bad++; $display("FAIL p0_step k=%0d got=%b want=%b", k, step, (k <= 2)); end
      total++; if (done !== (k == 4)) begin bad++; $display("FAIL p0_done k=%0d got=%b want=%b", k, done, (k == 4)); end
    end
    total++; if (position !== 16'd2) begin bad++; $display("FAIL p0_pos got=%0d want=2", position); end
  endtask

`ifdef STEP_RAMP_EN
  // RAMP_EXTRA=8, P=2, 0 -> 4: intervals 10,6,4,3 -> steps after edges
  // 10,16,20,23; dwell 2 -> DONE at 25; done after edge 26.
  task automatic test_ramp();
    logic             exp_step;
    logic [POS_W-1:0] exp_pos;
    do_reset();
    send_cmd(16'd4, 20'd2);
    exp_pos = 16'd0;
    for (int k = 1; k <= 28; k++) begin
      tick();
      exp_step = (k == 10) || (k == 16) || (k == 20) || (k == 23);
      if (exp_step) exp_pos = exp_pos + 16'd1;
      total++; if (step !== exp_step) begin bad++; $display("FAIL ramp_step k=%0d got=%b want=%b", k, step, exp_step); end
      total++; if (position !== exp_pos) begin bad++; $display("FAIL ramp_pos k=%0d got=%0d want=%0d", k, position, exp_pos); end
      total++; if (done !== (k == 26)) begin bad++; $display("FAIL ramp_done k=%0d got=%b want=%b", k, done, (k == 26)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_move();
    test_reverse_min_period();
    test_zero_length();
    test_abort();
    test_ignore_and_reset();
    test_period_zero();
`ifdef STEP_RAMP_EN
    test_ramp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stepper_move_ctrl.md
# stepper_move_ctrl

Move sequencer for the elevator stepper drive. It accepts absolute-position move commands and issues single-cycle `step` strobes at a programmable interval, with a direction level, to the 4-phase coil sequencer. It tracks the shaft position in steps and reports completion with a one-cycle `done` pulse after a settle dwell. It sits between the floor-request logic and the phase sequencer; the phase sequencer advances one phase per `step` strobe in the direction given by `dir`.

## Interface
- `POS_W`, 16: width of position and target, in steps.
- `DIV_W`, 20: width of the step interval, in clk cycles.
- `RAMP_EXTRA`, 256: extra cycles added to the first interval when ramping. Must be < 2^DIV_W.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `cmd_valid`  in  1  move command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_target`  in  POS_W  absolute target position, unsigned.
- `cmd_period`  in  DIV_W  step interval P in cycles; 0 is treated as 1.
- `abort`  in  1  stops stepping at once; level-sampled every cycle.
- `step`  out  1  one-cycle strobe; the sequencer advances one phase.
- `dir`  out  1  1 = clockwise/up (position increments), 0 = counterclockwise/down.
- `position`  out  POS_W  current position in steps.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a move, or an aborted move, finishes.

## Operation
- States: IDLE, RUN, DWELL, DONE.
- IDLE:
  - `cmd_ready`=1.
  - A command is accepted on `cmd_valid`&&`cmd_ready`, which latches the target and P.
  - If target == position: go to DONE; no steps are issued and `dir` is unchanged.
  - Otherwise: `dir` = (target > position), the interval counter loads P_eff, and the next state is RUN.
- RUN:
  - The counter decrements each cycle. When it reaches 1, `step` is registered high for one cycle, the counter reloads, and position ±1 updates on the same edge that raises `step`.
  - When the updated position equals target, go to DWELL; the counter loads P.
- DWELL: hold for P cycles with no steps (coil settle), then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- abort in RUN:
  - No further `step` is issued. Go to DWELL with the counter loaded to P.
  - Position keeps the steps already taken.
  - abort in any other state is ignored.
- Simultaneous abort and step boundary in RUN: abort wins and no step is issued.
- `cmd_valid` outside IDLE is ignored; it is not queued.
- Position never wraps. Direction comes from an unsigned comparison, so a move always terminates at target within the range 0..2^POS_W−1.
- The interval counter is DIV_W+1 bits wide so that P + RAMP_EXTRA cannot overflow.

## Timing
- Reset values:
  - state IDLE.
  - `step`=0, `dir`=1, `position`=0, `busy`=0, `done`=0, `cmd_ready`=1.
- Reset mid-move aborts immediately. Position returns to 0; no `done` pulse.
- `cmd_ready` and `busy` are decoded from the state register; the other outputs are registered.
- With ramp disabled, for a move of N>0 steps accepted at edge 0:
  - step k (1..N) is high in the cycle after edge k·P.
  - `done` is high in the cycle after edge (N+1)·P+1.
  - `busy` is high from edge 0 up to and including the `done` cycle.
- Zero-length move: `done` is high in the cycle after edge 1.
- Minimum P=1: a step strobe every cycle; `step` stays high for N consecutive cycles.

## Configuration
- `STEP_RAMP_EN` defined:
  - Acceleration ramp: the interval before step k is P + (RAMP_EXTRA >> (k−1)).
  - The extra term halves after every step until it reaches 0; the DWELL length is unaffected.
- `STEP_RAMP_EN` undefined: every interval is exactly P, and no ramp logic is built.

## Test plan
- Reset, then command target=5, P=4 (ramp off): five `step` pulses 4 cycles apart with `dir`=1 and position 1→5; `done` pulse 4 cycles after the last step plus 1; `cmd_ready` is back to 1 afterwards.
- From position 5, command target=2, P=1: three consecutive `step` cycles, `dir`=0, position ends at 2, exactly one `done` pulse.
- Command target equal to position: no `step`; `done` in the cycle after the edge after acceptance; `dir` holds its previous value.
- Target=100, P=10, abort asserted on the same cycle as the 3rd step boundary: only 2 steps are issued, position ends at 2, `done` follows after a 10-cycle dwell.
- `cmd_valid` held high with a new target during RUN: it is ignored. Reset asserted mid-move: position=0, `busy`=0, no `done` pulse.
- `STEP_RAMP_EN` defined, RAMP_EXTRA=8, P=2, target=4: step intervals are 10, 6, 4, 3 cycles.
